// File: rtl/mips_pkg.sv
// Shared constants for the memory stage: FSM state encoding and IO region layout.
// No logic here; imported by memory_io and gpio_bank.
package mips_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'hFFFF_FF00;
    localparam int          IO_IDX_LSB      = 2;
    localparam int          IO_IDX_W        = 4;

endpackage

// File: rtl/gpio_bank.sv
// GPIO output registers (byte-writable, 1-cycle update) plus two-flop input synchroniser.
// Reads are combinational from the synchronised copy; never applies backpressure.
module gpio_bank
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int GPIO_CHANNELS = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [DATA_WIDTH/8-1:0]               i_wr_be,
    input  logic [IO_IDX_W-1:0]                   i_idx,
    input  logic [DATA_WIDTH-1:0]                 i_wdata,
    output logic [DATA_WIDTH-1:0]                 o_rdata,
    output logic [GPIO_CHANNELS*DATA_WIDTH-1:0]   gpio_out,
    input  logic [GPIO_CHANNELS*DATA_WIDTH-1:0]   gpio_in
);

    logic [GPIO_CHANNELS*DATA_WIDTH-1:0] r_gpio_out;
    logic [GPIO_CHANNELS*DATA_WIDTH-1:0] r_sync1;
    logic [GPIO_CHANNELS*DATA_WIDTH-1:0] r_sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gpio_out <= '0;
            r_sync1    <= '0;
            r_sync2    <= '0;
        end else begin
            r_sync1 <= gpio_in;
            r_sync2 <= r_sync1;
            // Out-of-range channel indices match no channel, so the store is dropped.
            for (int ch = 0; ch < GPIO_CHANNELS; ch++) begin
                if (i_idx == IO_IDX_W'(ch)) begin
                    for (int b = 0; b < DATA_WIDTH/8; b++) begin
                        if (i_wr_be[b]) begin
                            r_gpio_out[ch*DATA_WIDTH + b*8 +: 8] <= i_wdata[b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        o_rdata = '0;
        for (int ch = 0; ch < GPIO_CHANNELS; ch++) begin
            if (i_idx == IO_IDX_W'(ch)) begin
                o_rdata = r_sync2[ch*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign gpio_out = r_gpio_out;

endmodule

// File: rtl/memory_io.sv
// MEM stage: decodes RAM vs GPIO region, waits on ram_ack (stall_mem while pending), registers WB.
// IO accesses are zero-wait; RAM latency follows ram_ack, with a bubble pushed to WB per stalled cycle.
module memory_io
    import mips_pkg::*;
#(
    parameter int          ADDR_WIDTH    = 9,
    parameter int          DATA_WIDTH    = 32,
    parameter int          REGS_DEPTH    = 5,
    parameter int          GPIO_CHANNELS = 4,
    parameter logic [31:0] IO_BASE       = IO_BASE_DEFAULT
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [DATA_WIDTH-1:0]               alu_data_mem,
    input  logic                                mem_re_mem,
    input  logic [DATA_WIDTH/8-1:0]             mem_we_mem,
    input  logic [DATA_WIDTH-1:0]               reg_t_data_mem,
    input  logic                                reg_d_we_mem,
    input  logic [REGS_DEPTH-1:0]               reg_d_addr_mem,
    input  logic                                reg_d_data_sel_mem,
    output logic                                stall_mem,
    output logic [DATA_WIDTH-1:0]               alu_data_wb,
    output logic [DATA_WIDTH-1:0]               mem_data_wb,
    output logic                                reg_d_we_wb,
    output logic [REGS_DEPTH-1:0]               reg_d_addr_wb,
    output logic                                reg_d_data_sel_wb,
    output logic                                ram_req,
    input  logic                                ram_ack,
    output logic [DATA_WIDTH/8-1:0]             ram_we_a,
    output logic [ADDR_WIDTH-1:0]               ram_addr_a,
    output logic [DATA_WIDTH-1:0]               ram_wdata_a,
    input  logic [DATA_WIDTH-1:0]               ram_rdata_a,
    output logic [GPIO_CHANNELS*DATA_WIDTH-1:0] gpio_out,
    input  logic [GPIO_CHANNELS*DATA_WIDTH-1:0] gpio_in
);

    logic                    w_access;
    logic                    w_io_hit;
    logic                    w_ram_hit;
    logic                    w_ram_req;
    logic [IO_IDX_W-1:0]     w_io_idx;
    logic [DATA_WIDTH/8-1:0] w_io_be;
    logic [DATA_WIDTH-1:0]   w_io_rdata;
    logic [0:0]              r_state;
    logic [0:0]              w_state_nxt;

    assign w_access  = mem_re_mem | (|mem_we_mem);
    assign w_io_hit  = w_access & (alu_data_mem[DATA_WIDTH-1:8] == IO_BASE[DATA_WIDTH-1:8]);
    assign w_ram_hit = w_access & ~w_io_hit;
    assign w_io_idx  = alu_data_mem[IO_IDX_LSB +: IO_IDX_W];
    assign w_io_be   = w_io_hit ? mem_we_mem : '0;

    always_comb begin
        w_state_nxt = r_state;
        w_ram_req   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ram_req = w_ram_hit;
                if (w_ram_hit & ~ram_ack) w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                w_ram_req = w_ram_hit;
                if (ram_ack | ~w_ram_hit) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Gating with rst_n abandons an in-flight access the moment reset asserts.
    assign ram_req     = w_ram_req & rst_n;
    assign stall_mem   = w_ram_hit & ~ram_ack & rst_n;
    assign ram_we_a    = (w_ram_hit & rst_n) ? mem_we_mem : '0;
    assign ram_addr_a  = alu_data_mem[ADDR_WIDTH+1:2];
    assign ram_wdata_a = reg_t_data_mem;

    gpio_bank #(
        .DATA_WIDTH    (DATA_WIDTH),
        .GPIO_CHANNELS (GPIO_CHANNELS)
    ) u_gpio_bank (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_wr_be  (w_io_be),
        .i_idx    (w_io_idx),
        .i_wdata  (reg_t_data_mem),
        .o_rdata  (w_io_rdata),
        .gpio_out (gpio_out),
        .gpio_in  (gpio_in)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_data_wb       <= '0;
            mem_data_wb       <= '0;
            reg_d_we_wb       <= 1'b0;
            reg_d_addr_wb     <= '0;
            reg_d_data_sel_wb <= 1'b0;
        end else if (stall_mem) begin
            reg_d_we_wb <= 1'b0;
        end else begin
            alu_data_wb       <= alu_data_mem;
            reg_d_we_wb       <= reg_d_we_mem;
            reg_d_addr_wb     <= reg_d_addr_mem;
            reg_d_data_sel_wb <= reg_d_data_sel_mem;
            if (w_ram_hit)     mem_data_wb <= ram_rdata_a;
            else if (w_io_hit) mem_data_wb <= w_io_rdata;
            else               mem_data_wb <= '0;
        end
    end

endmodule
